rx_slicer_ber: RTL

- Receive-side end of the TX filter chain.
- Takes the oversampled filter output (OS = 4 samples per symbol), decimates it at a selectable phase, and slices each symbol to a bit by sign.
- Finds the channel latency by searching for the delay that aligns the sliced bits with a local copy of the TX PRBS reference bit, then counts bit errors.
- Sits in the RX path of the top-level transceiver, fed by the FIR output and the TX PRBS bit.

---
 rtl/rx_slicer_ber_pkg.sv | 22 ++
 rtl/ber_counter.sv | 60 ++++++
 rtl/rx_slicer_ber.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rx_slicer_ber_pkg.sv
// Shared definitions for the RX slicer / BER block: FSM encoding, default
// geometry and the TX/RX bit-to-level mapping.
package rx_slicer_ber_pkg;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } ber_state_e;

  localparam int OS_DEF      = 4;
  localparam int DLY_LEN_DEF = 512;
  localparam int WIN_DEF     = 511;

  // Bit 0 travels as a positive level, bit 1 as a negative level.
  localparam logic BIT_POS = 1'b0;
  localparam logic BIT_NEG = 1'b1;

  function automatic logic slice_sign(input logic sign_bit);
    return sign_bit ? BIT_NEG : BIT_POS;
  endfunction

endpackage

// File: rtl/ber_counter.sv
// Saturating error / bit counters used once the receiver has locked.
module ber_counter
  import rx_slicer_ber_pkg::*;
#(
  parameter int NB_CNT = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              inc_i,
  input  logic              err_i,
  output logic [NB_CNT-1:0] err_count_o,
  output logic [NB_CNT-1:0] bit_count_o
);

  localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};
  localparam logic [NB_CNT-1:0] CNT_ONE = NB_CNT'(32'd1);

  logic [NB_CNT-1:0] err_q, err_d;
  logic [NB_CNT-1:0] bits_q, bits_d;

  // Next-state: clear dominates, otherwise count with saturation.
  always_comb begin
    err_d  = err_q;
    bits_d = bits_q;
    if (clear_i) begin
      err_d  = '0;
      bits_d = '0;
    end else if (inc_i) begin
      if (bits_q != CNT_MAX) begin
        bits_d = bits_q + CNT_ONE;
      end else begin
        bits_d = bits_q;
      end
      if (err_i && (err_q != CNT_MAX)) begin
        err_d = err_q + CNT_ONE;
      end else begin
        err_d = err_q;
      end
    end else begin
      err_d  = err_q;
      bits_d = bits_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_q  <= '0;
      bits_q <= '0;
    end else begin
      err_q  <= err_d;
      bits_q <= bits_d;
    end
  end

  assign err_count_o = err_q;
  assign bit_count_o = bits_q;

endmodule

// File: rtl/rx_slicer_ber.sv
// RX end of the TX filter chain: decimate, slice by sign, search the channel
// delay against the TX PRBS reference and count bit errors once aligned.
module rx_slicer_ber
  import rx_slicer_ber_pkg::*;
#(
  parameter int NB_INPUT  = 8,
  parameter int NBF_INPUT = 6,
  parameter int OS        = OS_DEF,
  parameter int DLY_LEN   = DLY_LEN_DEF,
  parameter int WIN       = WIN_DEF,
  parameter int NB_CNT    = 64
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [$clog2(OS)-1:0]      i_phase,
  input  logic [NB_INPUT-1:0]        i_sample,
  input  logic                       i_ref_bit,
  output logic                       o_bit,
  output logic                       o_bit_valid,
  output logic                       o_locked,
  output logic [$clog2(DLY_LEN)-1:0] o_delay,
  output logic [NB_CNT-1:0]          o_err_count,
  output logic [NB_CNT-1:0]          o_bit_count
);

  localparam int NB_PH    = $clog2(OS);
  localparam int NB_DLY   = $clog2(DLY_LEN);
  localparam int NB_WIN   = $clog2(WIN + 1);
  localparam int INT_BITS = NB_INPUT - NBF_INPUT;
  // The sign sits on top of the integer part of the Q format.
  localparam int SIGN_BIT = NBF_INPUT + INT_BITS - 1;

  localparam logic [NB_PH-1:0]  PH_ONE   = NB_PH'(32'd1);
  localparam logic [NB_DLY-1:0] DLY_ONE  = NB_DLY'(32'd1);
  localparam logic [NB_DLY-1:0] DLY_LAST = NB_DLY'(DLY_LEN - 1);
  localparam logic [NB_WIN-1:0] WIN_ONE  = NB_WIN'(32'd1);
  localparam logic [NB_WIN-1:0] WIN_LAST = NB_WIN'(WIN - 1);

  ber_state_e         state_q, state_d;
  logic [NB_PH-1:0]   phase_q, phase_d;
  logic [DLY_LEN-1:0] ref_sr_q, ref_sr_d, ref_next_s;
  logic [NB_DLY-1:0]  delay_q, delay_d;
  logic [NB_WIN-1:0]  win_cnt_q, win_cnt_d;
  logic               win_err_q, win_err_d;
  logic               bit_q, bit_d;
  logic               bit_valid_q, bit_valid_d;
  logic               strobe_s, slice_s, cmp_s, err_s;
  logic               cnt_clear_s, cnt_inc_s;
  logic               unused_bits_s;

  assign unused_bits_s = ^{i_sample[SIGN_BIT-1:0], ref_sr_q[DLY_LEN-1]};

  // Phase counter, slicer and reference delay line.
  always_comb begin
    strobe_s    = i_enable && (phase_q == i_phase);
    phase_d     = i_enable ? (phase_q + PH_ONE) : phase_q;
    ref_next_s  = {ref_sr_q[DLY_LEN-2:0], i_ref_bit};
    cmp_s       = ref_next_s[delay_q];
    slice_s     = slice_sign(i_sample[SIGN_BIT]);
    err_s       = slice_s ^ cmp_s;
    ref_sr_d    = strobe_s ? ref_next_s : ref_sr_q;
    bit_valid_d = strobe_s;
    bit_d       = strobe_s ? slice_s : bit_q;
  end

  // Delay search: a window with no error locks, otherwise try the next delay.
  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    case (state_q)
      ST_SEARCH: begin
        if (strobe_s) begin
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = 1'b0;
            if (!(win_err_q || err_s)) begin
              state_d = ST_LOCKED;
            end else begin
              delay_d = (delay_q == DLY_LAST) ? '0 : (delay_q + DLY_ONE);
            end
          end else begin
            win_cnt_d = win_cnt_q + WIN_ONE;
            win_err_d = win_err_q | err_s;
          end
        end else begin
          win_cnt_d = win_cnt_q;
          win_err_d = win_err_q;
        end
      end
      ST_LOCKED: begin
        state_d = ST_LOCKED;
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q     <= ST_SEARCH;
      phase_q     <= '0;
      ref_sr_q    <= '0;
      delay_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= 1'b0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ref_sr_q    <= ref_sr_d;
      delay_q     <= delay_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign cnt_clear_s = (state_q != ST_LOCKED);
  assign cnt_inc_s   = strobe_s && (state_q == ST_LOCKED);

  ber_counter #(
    .NB_CNT (NB_CNT)
  ) u_ber_counter (
    .clk_i       (clock),
    .rst_n_i     (i_reset),
    .clear_i     (cnt_clear_s),
    .inc_i       (cnt_inc_s),
    .err_i       (err_s),
    .err_count_o (o_err_count),
    .bit_count_o (o_bit_count)
  );

  assign o_bit       = bit_q;
  assign o_bit_valid = bit_valid_q;
  assign o_locked    = (state_q == ST_LOCKED);
  assign o_delay     = delay_q;

endmodule
